// File: rtl/mc_control_if.sv
// Control/bus signal bundle for mc_control: IR fields and handshakes in, datapath strobes out.
// master = the controller, slave = the datapath/bus side driving op/funct/zero/mem_ready.
interface mc_control_if #(
  parameter int ALU_OP_W = 3,
  parameter int STATE_W  = 3
) ();
  logic [5:0]          op;
  logic [5:0]          funct;
  logic                zero;
  logic                mem_ready;
  logic                bus_read;
  logic                bus_write;
  logic                ir_write;
  logic                pc_write;
  logic [1:0]          pc_src;
  logic [ALU_OP_W-1:0] alu_op;
  logic                i_or_r;
  logic                reg_write;
  logic                load;
  logic                trap;
  logic [STATE_W-1:0]  state;

  modport master (
    input  op, funct, zero, mem_ready,
    output bus_read, bus_write, ir_write, pc_write, pc_src, alu_op,
           i_or_r, reg_write, load, trap, state
  );

  modport slave (
    output op, funct, zero, mem_ready,
    input  bus_read, bus_write, ir_write, pc_write, pc_src, alu_op,
           i_or_r, reg_write, load, trap, state
  );
endinterface

// File: rtl/mc_control.sv
// Multi-cycle MIPS control FSM: FETCH/DECODE/EXEC/MEM/WB with bus-timeout and illegal-op trap.
// Define MC_CONTROL_BRANCH_EN to make BEQ and J legal (3-cycle branch/jump through EXEC).
module mc_control #(
  parameter int ALU_OP_W    = 3,
  parameter int MEM_TIMEOUT = 15,
  parameter int STATE_W     = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  mc_control_if.master bus
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] FN_TBL [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};
  localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

  state_t     state_reg, state_next;
  logic [7:0] wait_cnt_reg, wait_cnt_next;
  logic [5:0] op_reg, funct_reg;
  logic [4:0] funct_hit;
  logic       legal;
  logic [2:0] alu_code;

  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_funct
      assign funct_hit[gi] = (bus.funct == FN_TBL[gi]);
    end
  endgenerate

  always_comb begin
    legal = 1'b0;
    case (bus.op)
      OP_R:                    legal = |funct_hit;
      OP_ADDI, OP_LW, OP_SW:   legal = 1'b1;
`ifdef MC_CONTROL_BRANCH_EN
      OP_BEQ, OP_J:            legal = 1'b1;
`endif
      default:                 legal = 1'b0;
    endcase
  end

`ifndef MC_CONTROL_BRANCH_EN
  logic unused_zero;
  assign unused_zero = bus.zero;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= S_FETCH;
      wait_cnt_reg <= '0;
      op_reg       <= '0;
      funct_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      if (state_reg == S_DECODE) begin
        op_reg    <= bus.op;
        funct_reg <= bus.funct;
      end
    end
  end

  // Everything is gated by rst_n so strobes fall the moment reset is asserted.
  always_comb begin
    state_next     = state_reg;
    wait_cnt_next  = '0;
    bus.bus_read   = 1'b0;
    bus.bus_write  = 1'b0;
    bus.ir_write   = 1'b0;
    bus.pc_write   = 1'b0;
    bus.pc_src     = 2'd0;
    bus.i_or_r     = 1'b0;
    bus.reg_write  = 1'b0;
    bus.load       = 1'b0;
    bus.trap       = 1'b0;
    alu_code       = 3'd0;
    if (rst_n) begin
      case (state_reg)
        S_FETCH: begin
          bus.bus_read = 1'b1;
          if (bus.mem_ready) begin
            bus.ir_write = 1'b1;
            bus.pc_write = 1'b1;
            state_next   = S_DECODE;
          end else if (wait_cnt_reg == TIMEOUT) begin
            state_next = S_TRAP;
          end else begin
            wait_cnt_next = wait_cnt_reg + 8'd1;
          end
        end
        S_DECODE: state_next = legal ? S_EXEC : S_TRAP;
        S_EXEC: begin
          case (op_reg)
            OP_R: begin
              bus.i_or_r = 1'b1;
              state_next = S_WB;
              case (funct_reg)
                6'h20:   alu_code = 3'd1;
                6'h22:   alu_code = 3'd2;
                6'h24:   alu_code = 3'd3;
                6'h25:   alu_code = 3'd4;
                6'h2a:   alu_code = 3'd5;
                default: alu_code = 3'd0;
              endcase
            end
            OP_ADDI: begin
              alu_code   = 3'd1;
              state_next = S_WB;
            end
            OP_LW, OP_SW: begin
              alu_code   = 3'd1;
              state_next = S_MEM;
            end
`ifdef MC_CONTROL_BRANCH_EN
            OP_BEQ: begin
              alu_code     = 3'd2;
              bus.i_or_r   = 1'b1;
              bus.pc_write = bus.zero;
              bus.pc_src   = 2'd1;
              state_next   = S_FETCH;
            end
            OP_J: begin
              bus.pc_write = 1'b1;
              bus.pc_src   = 2'd2;
              state_next   = S_FETCH;
            end
`endif
            default: state_next = S_TRAP;
          endcase
        end
        S_MEM: begin
          bus.bus_read  = (op_reg == OP_LW);
          bus.bus_write = (op_reg != OP_LW);
          if (bus.mem_ready) begin
            state_next = (op_reg == OP_LW) ? S_WB : S_FETCH;
          end else if (wait_cnt_reg == TIMEOUT) begin
            state_next = S_TRAP;
          end else begin
            wait_cnt_next = wait_cnt_reg + 8'd1;
          end
        end
        S_WB: begin
          bus.reg_write = 1'b1;
          bus.load      = (op_reg == OP_LW);
          bus.i_or_r    = (op_reg == OP_R);
          state_next    = S_FETCH;
        end
        S_TRAP:  bus.trap = 1'b1;
        default: state_next = S_TRAP;
      endcase
    end
  end

  assign bus.alu_op = ALU_OP_W'(alu_code);
  assign bus.state  = STATE_W'(state_reg);

endmodule

// File: tb/tb_mc_control.sv
// Directed bench for mc_control: vector table for normal instruction flows, hand sequences
// for trap, bus timeout boundary, asynchronous abort and the optional branch opcodes.
module tb_mc_control;

  typedef struct packed {
    logic [2:0] st;
    logic [3:0] strb;  // {bus_read, bus_write, ir_write, pc_write}
    logic [1:0] ps;
    logic [2:0] alu;
    logic [3:0] misc;  // {i_or_r, reg_write, load, trap}
  } out_t;

  typedef struct {
    string      nm;
    logic [5:0] op;
    logic [5:0] fn;
    logic       mr;
    out_t       want;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;
  vec_t vq[$];

  mc_control_if #(.ALU_OP_W(3), .STATE_W(3)) bus ();

  mc_control #(.ALU_OP_W(3), .MEM_TIMEOUT(15), .STATE_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic out_t mk(logic [2:0] st, logic [3:0] strb, logic [1:0] ps,
                              logic [2:0] alu, logic [3:0] misc);
    out_t o;
    o.st = st; o.strb = strb; o.ps = ps; o.alu = alu; o.misc = misc;
    return o;
  endfunction

  function automatic out_t sample();
    return mk(bus.state, {bus.bus_read, bus.bus_write, bus.ir_write, bus.pc_write},
              bus.pc_src, bus.alu_op, {bus.i_or_r, bus.reg_write, bus.load, bus.trap});
  endfunction

  task automatic add(string nm, logic [5:0] op, logic [5:0] fn, logic mr, logic [2:0] st,
                     logic [3:0] strb, logic [1:0] ps, logic [2:0] alu, logic [3:0] misc);
    vec_t v;
    v.nm = nm; v.op = op; v.fn = fn; v.mr = mr; v.want = mk(st, strb, ps, alu, misc);
    vq.push_back(v);
  endtask

  task automatic check(string nm, out_t want);
    out_t got;
    got = sample();
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got st=%0d strb=%b ps=%0d alu=%0d misc=%b, want st=%0d strb=%b ps=%0d alu=%0d misc=%b",
               nm, got.st, got.strb, got.ps, got.alu, got.misc,
               want.st, want.strb, want.ps, want.alu, want.misc);
    end else begin
      $display("ok   %s: st=%0d strb=%b ps=%0d alu=%0d misc=%b",
               nm, got.st, got.strb, got.ps, got.alu, got.misc);
    end
  endtask

  // Inputs applied at a falling edge, checked 1ns later, consumed at the next rising edge.
  task automatic step(string nm, logic [5:0] op, logic [5:0] fn, logic zero, logic mr, out_t want);
    bus.op = op; bus.funct = fn; bus.zero = zero; bus.mem_ready = mr;
    #1;
    check(nm, want);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.mem_ready = 1'b1;
    #1;
    check("reset", mk(0, 4'b0000, 0, 0, 4'b0000));
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [5:0] fn_tbl [5];
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    bus.op = '0; bus.funct = '0; bus.zero = 1'b0; bus.mem_ready = 1'b0;

    fn_tbl = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};
    for (int i = 0; i < 5; i++) begin
      add("r_fetch", 6'h00, fn_tbl[i], 1, 0, 4'b1011, 0, 0, 4'b0000);
      add("r_decode", 6'h00, fn_tbl[i], 1, 1, 4'b0000, 0, 0, 4'b0000);
      add("r_exec", 6'h3f, 6'h00, 1, 2, 4'b0000, 0, 3'(i + 1), 4'b1000);
      add("r_wb", 6'h3f, 6'h00, 1, 4, 4'b0000, 0, 0, 4'b1100);
    end
    add("addi_fetch", 6'h08, 0, 1, 0, 4'b1011, 0, 0, 4'b0000);
    add("addi_decode", 6'h08, 0, 1, 1, 4'b0000, 0, 0, 4'b0000);
    add("addi_exec", 6'h08, 0, 1, 2, 4'b0000, 0, 1, 4'b0000);
    add("addi_wb", 6'h00, 0, 1, 4, 4'b0000, 0, 0, 4'b0100);
    add("lw_fwait0", 6'h23, 0, 0, 0, 4'b1000, 0, 0, 4'b0000);
    add("lw_fwait1", 6'h23, 0, 0, 0, 4'b1000, 0, 0, 4'b0000);
    add("lw_fetch", 6'h23, 0, 1, 0, 4'b1011, 0, 0, 4'b0000);
    add("lw_decode", 6'h23, 0, 0, 1, 4'b0000, 0, 0, 4'b0000);
    add("lw_exec", 6'h23, 0, 1, 2, 4'b0000, 0, 1, 4'b0000);
    add("lw_mwait0", 6'h23, 0, 0, 3, 4'b1000, 0, 0, 4'b0000);
    add("lw_mwait1", 6'h23, 0, 0, 3, 4'b1000, 0, 0, 4'b0000);
    add("lw_mwait2", 6'h23, 0, 0, 3, 4'b1000, 0, 0, 4'b0000);
    add("lw_mem", 6'h23, 0, 1, 3, 4'b1000, 0, 0, 4'b0000);
    add("lw_wb", 6'h23, 0, 1, 4, 4'b0000, 0, 0, 4'b0110);
    add("sw_fetch", 6'h2b, 0, 1, 0, 4'b1011, 0, 0, 4'b0000);
    add("sw_decode", 6'h2b, 0, 1, 1, 4'b0000, 0, 0, 4'b0000);
    add("sw_exec", 6'h2b, 0, 1, 2, 4'b0000, 0, 1, 4'b0000);
    add("sw_mwait", 6'h2b, 0, 0, 3, 4'b0100, 0, 0, 4'b0000);
    add("sw_mem", 6'h2b, 0, 1, 3, 4'b0100, 0, 0, 4'b0000);
    add("sw_back", 6'h00, 6'h20, 0, 0, 4'b1000, 0, 0, 4'b0000);

    repeat (2) @(negedge clk);
    check("reset", mk(0, 4'b0000, 0, 0, 4'b0000));
    rst_n = 1'b1;
    foreach (vq[i]) step(vq[i].nm, vq[i].op, vq[i].fn, 1'b0, vq[i].mr, vq[i].want);

    // Illegal opcode: trap is sticky with strobes quiet until reset.
    do_reset();
    step("il_fetch", 6'h3f, 0, 0, 1, mk(0, 4'b1011, 0, 0, 4'b0000));
    step("il_decode", 6'h3f, 0, 0, 1, mk(1, 4'b0000, 0, 0, 4'b0000));
    for (int i = 0; i < 20; i++) step("trap_hold", 6'h3f, 0, 0, i[0], mk(7, 4'b0000, 0, 0, 4'b0001));
    do_reset();
    step("after_trap", 6'h00, 6'h01, 0, 1, mk(0, 4'b1011, 0, 0, 4'b0000));
    step("ilfn_decode", 6'h00, 6'h01, 0, 1, mk(1, 4'b0000, 0, 0, 4'b0000));
    step("ilfn_trap", 6'h00, 6'h20, 0, 1, mk(7, 4'b0000, 0, 0, 4'b0001));

    // FETCH timeout: sixteen idle cycles (count 0..15), trap on the last.
    do_reset();
    for (int i = 0; i < 16; i++) step("to_wait", 6'h00, 6'h20, 0, 0, mk(0, 4'b1000, 0, 0, 4'b0000));
    step("to_trap", 6'h00, 6'h20, 0, 1, mk(7, 4'b0000, 0, 0, 4'b0001));
    do_reset();
    for (int i = 0; i < 15; i++) step("edge_wait", 6'h00, 6'h20, 0, 0, mk(0, 4'b1000, 0, 0, 4'b0000));
    step("edge_ready", 6'h00, 6'h20, 0, 1, mk(0, 4'b1011, 0, 0, 4'b0000));
    step("edge_decode", 6'h00, 6'h20, 0, 0, mk(1, 4'b0000, 0, 0, 4'b0000));

    // Asynchronous abort while in WB.
    do_reset();
    step("ab_fetch", 6'h00, 6'h20, 0, 1, mk(0, 4'b1011, 0, 0, 4'b0000));
    step("ab_decode", 6'h00, 6'h20, 0, 1, mk(1, 4'b0000, 0, 0, 4'b0000));
    step("ab_exec", 6'h00, 6'h20, 0, 1, mk(2, 4'b0000, 0, 1, 4'b1000));
    #1;
    check("ab_wb", mk(4, 4'b0000, 0, 0, 4'b1100));
    rst_n = 1'b0;
    #1;
    check("ab_abort", mk(0, 4'b0000, 0, 0, 4'b0000));
    @(negedge clk);
    rst_n = 1'b1;
    step("ab_refetch", 6'h04, 0, 0, 1, mk(0, 4'b1011, 0, 0, 4'b0000));

`ifdef MC_CONTROL_BRANCH_EN
    step("beq_decode", 6'h04, 0, 1, 1, mk(1, 4'b0000, 0, 0, 4'b0000));
    step("beq_exec_z1", 6'h04, 0, 1, 1, mk(2, 4'b0001, 1, 2, 4'b1000));
    step("beq_fetch", 6'h04, 0, 0, 1, mk(0, 4'b1011, 0, 0, 4'b0000));
    step("beq2_decode", 6'h04, 0, 0, 1, mk(1, 4'b0000, 0, 0, 4'b0000));
    step("beq_exec_z0", 6'h02, 0, 0, 1, mk(2, 4'b0000, 1, 2, 4'b1000));
    step("j_fetch", 6'h02, 0, 0, 1, mk(0, 4'b1011, 0, 0, 4'b0000));
    step("j_decode", 6'h02, 0, 0, 1, mk(1, 4'b0000, 0, 0, 4'b0000));
    step("j_exec", 6'h00, 0, 0, 1, mk(2, 4'b0001, 2, 0, 4'b0000));
    step("j_back", 6'h00, 0, 0, 1, mk(0, 4'b1011, 0, 0, 4'b0000));
`else
    step("beq_decode", 6'h04, 0, 1, 1, mk(1, 4'b0000, 0, 0, 4'b0000));
    step("beq_trap", 6'h04, 0, 1, 1, mk(7, 4'b0000, 0, 0, 4'b0001));
    do_reset();
    step("j_fetch", 6'h02, 0, 0, 1, mk(0, 4'b1011, 0, 0, 4'b0000));
    step("j_decode", 6'h02, 0, 0, 1, mk(1, 4'b0000, 0, 0, 4'b0000));
    step("j_trap", 6'h02, 0, 0, 1, mk(7, 4'b0000, 0, 0, 4'b0001));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
